// File: rtl/sub_nibble_serial_pkg.sv
// -----------------------------------------------------------------------------
// subnib_pkg
// Shared definitions for the serial uLBC substitution layer:
//   - SBOX / SBOX_INV : 4-bit S-box and its inverse (the inverse table only
//                       exists when SUBNIB_INV_EN is defined)
//   - subnib_state_e  : control FSM states
//   - subnib_params_ok: STATE_W / LANES legality check used at elaboration
//   - subnib_cnt_w    : beat counter width, max(1, $clog2(beats))
// Optional feature macro: SUBNIB_INV_EN
// -----------------------------------------------------------------------------
package subnib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } subnib_state_e;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

`ifdef SUBNIB_INV_EN
    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };
`endif

    // State must split into whole nibbles, and the nibbles into whole beats.
    function automatic logic subnib_params_ok(input int state_w, input int lanes);
        logic ok_s;
        if ((state_w <= 32'sd0) || (lanes <= 32'sd0)) begin
            ok_s = 1'b0;
        end else if ((state_w % 32'sd4) != 32'sd0) begin
            ok_s = 1'b0;
        end else if (((state_w / 32'sd4) % lanes) != 32'sd0) begin
            ok_s = 1'b0;
        end else begin
            ok_s = 1'b1;
        end
        return ok_s;
    endfunction

    function automatic int subnib_cnt_w(input int beats);
        return (beats > 32'sd1) ? $clog2(beats) : 32'sd1;
    endfunction

endpackage

// File: rtl/sub_nibble_serial_sbox.sv
// -----------------------------------------------------------------------------
// sbox_nibble
// Combinational 4-bit S-box lookup.
// Ports:
//   inv  : select inverse table (present only with SUBNIB_INV_EN)
//   din  : input nibble
//   dout : substituted nibble
// -----------------------------------------------------------------------------
module sbox_nibble
    import subnib_pkg::*;
(
`ifdef SUBNIB_INV_EN
    input  logic       inv,
`endif
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Table lookup, forward or inverse.
    always_comb begin
`ifdef SUBNIB_INV_EN
        if (inv) begin
            dout = SBOX_INV[din];
        end else begin
            dout = SBOX[din];
        end
`else
        dout = SBOX[din];
`endif
    end

endmodule

// File: rtl/sub_nibble_serial.sv
// -----------------------------------------------------------------------------
// sub_nibble_serial
// Area-scalable uLBC substitution layer. The state is loaded into a shift
// register; each BUSY cycle the top LANES nibbles are substituted and the
// register is rotated left by one slice, so after BEATS cycles every nibble
// has been substituted and the register is back in original order.
// Parameters: STATE_W (state bits, multiple of 4), LANES (S-boxes per cycle).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready high only in IDLE)
//   s_in                : input state, nibble 0 in the MSBs
//   inv                 : inverse select, sampled on accept (SUBNIB_INV_EN only)
//   out_valid/out_ready : output handshake
//   s_out               : result, valid only while out_valid is high
// Optional feature macro: SUBNIB_INV_EN
// -----------------------------------------------------------------------------
module sub_nibble_serial
    import subnib_pkg::*;
#(
    parameter int STATE_W = 128,
    parameter int LANES   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] s_in,
`ifdef SUBNIB_INV_EN
    input  logic               inv,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] s_out
);

    localparam int SLICE_W = 32'sd4 * LANES;
    localparam int BEATS   = (SLICE_W > 32'sd0) ? (STATE_W / SLICE_W) : 32'sd1;
    localparam int CNT_W   = subnib_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'sd1);

    if (!subnib_params_ok(STATE_W, LANES)) begin : g_param_check
        $fatal(1, "sub_nibble_serial: illegal STATE_W/LANES combination");
    end

    subnib_state_e      state_r;
    subnib_state_e      state_nx_s;
    logic [CNT_W-1:0]   beat_r;
    logic [STATE_W-1:0] shreg_r;
    logic [STATE_W-1:0] merged_s;
    logic [STATE_W-1:0] rot_s;
    logic [SLICE_W-1:0] sub_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               in_ready_nx_s;
    logic               out_valid_nx_s;
`ifdef SUBNIB_INV_EN
    logic               inv_r;
`endif

    // S-box lanes: lane k handles nibble k of the current top slice.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sbox_nibble u_sbox (
`ifdef SUBNIB_INV_EN
            .inv  (inv_r),
`endif
            .din  (shreg_r[STATE_W-1-4*k -: 4]),
            .dout (sub_s[SLICE_W-1-4*k -: 4])
        );
    end

    // Substitute the top slice, then rotate it to the bottom. Shifts are used
    // so that the single-beat case (slice == whole state) needs no special form.
    always_comb begin
        merged_s = shreg_r;
        merged_s[STATE_W-1 -: SLICE_W] = sub_s;
        rot_s = (merged_s << SLICE_W) | (merged_s >> (STATE_W - SLICE_W));
    end

    // FSM state register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (beat_r == LAST_BEAT) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flops line up with
    // the state register.
    always_comb begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        case (state_nx_s)
            IDLE:    in_ready_nx_s  = 1'b1;
            BUSY:    in_ready_nx_s  = 1'b0;
            DONE:    out_valid_nx_s = 1'b1;
            default: in_ready_nx_s  = 1'b0;
        endcase
    end

    // Datapath: load on accept, substitute-and-rotate while busy, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= '0;
            beat_r  <= '0;
`ifdef SUBNIB_INV_EN
            inv_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shreg_r <= s_in;
                        beat_r  <= '0;
`ifdef SUBNIB_INV_EN
                        inv_r   <= inv;
`endif
                    end
                end
                BUSY: begin
                    shreg_r <= rot_s;
                    if (beat_r == LAST_BEAT) begin
                        beat_r <= '0;
                    end else begin
                        beat_r <= beat_r + CNT_ONE;
                    end
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign s_out     = shreg_r;

endmodule

// File: tb/tb_sub_nibble_serial.sv
module tb_sub_nibble_serial;

    localparam logic [3:0] TB_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam logic [127:0] P1   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] EXP1 = 128'hC56B90AD3EF84712_21748FE3DA09B65C;
    localparam logic [127:0] P2   = 128'hFFFF0000_A5A5A5A5_0F1E2D3C_4B5A6978;
    localparam logic [127:0] EXP2 = 128'h2222CCCC_F0F0F0F0_C25167B4_980FAED3;
    localparam logic [127:0] EXP0 = 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC;
    localparam int LAT_MAX = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   sw_iv = 4'b0000;
    logic [3:0]   sw_or = 4'b0000;
    logic [3:0]   sw_ir;
    logic [3:0]   sw_ov;
    logic [127:0] sw_sin [3];
    logic [127:0] sw_sout [3];
    logic [63:0]  sin3 = 64'd0;
    logic [63:0]  sout3;
`ifdef SUBNIB_INV_EN
    logic [3:0]   sw_inv = 4'b0000;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int beats_tab [4] = '{4, 32, 1, 4};

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 3; i++) sw_sin[i] = 128'd0;
    end

    sub_nibble_serial #(.STATE_W(128), .LANES(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .s_in(sw_sin[0]),
`ifdef SUBNIB_INV_EN
        .inv(sw_inv[0]),
`endif
        .out_valid(sw_ov[0]), .out_ready(sw_or[0]), .s_out(sw_sout[0]));

    sub_nibble_serial #(.STATE_W(128), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .s_in(sw_sin[1]),
`ifdef SUBNIB_INV_EN
        .inv(sw_inv[1]),
`endif
        .out_valid(sw_ov[1]), .out_ready(sw_or[1]), .s_out(sw_sout[1]));

    sub_nibble_serial #(.STATE_W(128), .LANES(32)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .s_in(sw_sin[2]),
`ifdef SUBNIB_INV_EN
        .inv(sw_inv[2]),
`endif
        .out_valid(sw_ov[2]), .out_ready(sw_or[2]), .s_out(sw_sout[2]));

    sub_nibble_serial #(.STATE_W(64), .LANES(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(sw_iv[3]), .in_ready(sw_ir[3]), .s_in(sin3),
`ifdef SUBNIB_INV_EN
        .inv(sw_inv[3]),
`endif
        .out_valid(sw_ov[3]), .out_ready(sw_or[3]), .s_out(sout3));

    function automatic logic [127:0] ref_sub(input logic [127:0] x, input int w);
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < w / 4; i++) r[4*i +: 4] = TB_SBOX[x[4*i +: 4]];
        return r;
    endfunction

    // Drive one job into instance j with out_ready high; returns result and latency.
    task automatic run_job(input int j, input logic [127:0] din,
                           output logic [127:0] dout, output int lat);
        @(negedge clk);
        if (j == 3) sin3 = din[63:0];
        else sw_sin[j] = din;
        sw_iv[j] = 1'b1;
        sw_or[j] = 1'b1;
        @(negedge clk);
        sw_iv[j] = 1'b0;
        lat = 0;
        while (!sw_ov[j] && lat < LAT_MAX) begin
            @(negedge clk);
            lat++;
        end
        dout = (j == 3) ? {64'd0, sout3} : sw_sout[j];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (sw_ir[j] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 1", j, sw_ir[j]);
            end
            n_checks++;
            if (sw_ov[j] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", j, sw_ov[j]);
            end
        end
        n_checks++;
        if (sw_sout[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_s_out: got %h expected 0", sw_sout[0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [127:0] d;
        int lat;
        run_job(0, 128'd0, d, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d expected 4", lat);
        end
        n_checks++;
        if (d !== EXP0) begin
            n_fail++;
            $display("FAIL zero_data: got %h expected %h", d, EXP0);
        end
    endtask

    task automatic test_pattern();
        logic [127:0] d;
        int lat;
        run_job(0, P1, d, lat);
        n_checks++;
        if (d !== EXP1) begin
            n_fail++;
            $display("FAIL pattern_hand: got %h expected %h", d, EXP1);
        end
        n_checks++;
        if (d !== ref_sub(P1, 128)) begin
            n_fail++;
            $display("FAIL pattern_model: got %h expected %h", d, ref_sub(P1, 128));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        sw_sin[0] = P2;
        sw_iv[0] = 1'b1;
        sw_or[0] = 1'b0;
        @(negedge clk);
        sw_iv[0] = 1'b0;
        lat = 0;
        while (!sw_ov[0] && lat < LAT_MAX) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (sw_ov[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_out_valid c=%0d: got %b expected 1", c, sw_ov[0]);
            end
            n_checks++;
            if (sw_sout[0] !== EXP2) begin
                n_fail++;
                $display("FAIL bp_s_out c=%0d: got %h expected %h", c, sw_sout[0], EXP2);
            end
            n_checks++;
            if (sw_ir[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, sw_ir[0]);
            end
            if (c == 3) begin
                sw_sin[0] = ~P2;
                sw_iv[0] = 1'b1;
            end else begin
                sw_iv[0] = 1'b0;
            end
            @(negedge clk);
        end
        sw_or[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sw_ov[0] !== 1'b0 || sw_ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1", sw_ov[0], sw_ir[0]);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (sw_ov[0] !== 1'b0 || sw_ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_phantom_job: got ov=%b ir=%b expected ov=0 ir=1", sw_ov[0], sw_ir[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sw_sin[0] = P1;
        sw_iv[0] = 1'b1;
        sw_or[0] = 1'b1;
        for (int t = 0; t <= 12; t++) begin
            n_checks++;
            if (sw_ir[0] !== ((t % 6) == 0)) begin
                n_fail++;
                $display("FAIL b2b_in_ready t=%0d: got %b expected %b", t, sw_ir[0], ((t % 6) == 0));
            end
            n_checks++;
            if (sw_ov[0] !== ((t % 6) == 5)) begin
                n_fail++;
                $display("FAIL b2b_out_valid t=%0d: got %b expected %b", t, sw_ov[0], ((t % 6) == 5));
            end
            if ((t % 6) == 5) begin
                n_checks++;
                if (sw_sout[0] !== EXP1) begin
                    n_fail++;
                    $display("FAIL b2b_data t=%0d: got %h expected %h", t, sw_sout[0], EXP1);
                end
            end
            if (t < 12) @(negedge clk);
        end
        sw_iv[0] = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic test_rst_mid_busy();
        logic [127:0] d;
        int lat;
        @(negedge clk);
        sw_sin[0] = P2;
        sw_iv[0] = 1'b1;
        sw_or[0] = 1'b1;
        @(negedge clk);
        sw_iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (sw_ir[0] !== 1'b1 || sw_ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_handshake: got ir=%b ov=%b expected ir=1 ov=0", sw_ir[0], sw_ov[0]);
        end
        n_checks++;
        if (sw_sout[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL rst_busy_s_out: got %h expected 0", sw_sout[0]);
        end
        run_job(0, P1, d, lat);
        n_checks++;
        if (d !== EXP1 || lat !== 4) begin
            n_fail++;
            $display("FAIL rst_busy_fresh_job: got %h lat %0d expected %h lat 4", d, lat, EXP1);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] d;
        logic [127:0] din;
        logic [127:0] exp_d;
        int lat;
        int w;
        for (int j = 0; j < 4; j++) begin
            w = (j == 3) ? 64 : 128;
            din = (j == 3) ? {64'd0, P1[127:64]} : P1;
            exp_d = (j == 3) ? {64'd0, EXP1[127:64]} : EXP1;
            run_job(j, din, d, lat);
            n_checks++;
            if (lat !== beats_tab[j]) begin
                n_fail++;
                $display("FAIL sweep_latency[%0d]: got %0d expected %0d", j, lat, beats_tab[j]);
            end
            n_checks++;
            if (d !== exp_d) begin
                n_fail++;
                $display("FAIL sweep_data_hand[%0d]: got %h expected %h", j, d, exp_d);
            end
            n_checks++;
            if (d !== ref_sub(din, w)) begin
                n_fail++;
                $display("FAIL sweep_data_model[%0d]: got %h expected %h", j, d, ref_sub(din, w));
            end
        end
    endtask

`ifdef SUBNIB_INV_EN
    task automatic test_inv();
        logic [127:0] y;
        logic [127:0] z;
        int lat;
        sw_inv[0] = 1'b0;
        run_job(0, P1, y, lat);
        n_checks++;
        if (y !== EXP1) begin
            n_fail++;
            $display("FAIL inv_forward: got %h expected %h", y, EXP1);
        end
        sw_inv[0] = 1'b1;
        run_job(0, y, z, lat);
        n_checks++;
        if (z !== P1) begin
            n_fail++;
            $display("FAIL inv_roundtrip: got %h expected %h", z, P1);
        end
        @(negedge clk);
        sw_sin[0] = P2;
        sw_inv[0] = 1'b0;
        sw_iv[0] = 1'b1;
        sw_or[0] = 1'b1;
        @(negedge clk);
        sw_iv[0] = 1'b0;
        lat = 0;
        while (!sw_ov[0] && lat < LAT_MAX) begin
            sw_inv[0] = ~sw_inv[0];
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (sw_sout[0] !== EXP2 || lat !== 4) begin
            n_fail++;
            $display("FAIL inv_toggle_busy: got %h lat %0d expected %h lat 4", sw_sout[0], lat, EXP2);
        end
        sw_inv[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_pattern();
        test_backpressure();
        test_back_to_back();
        test_rst_mid_busy();
        test_sweep();
`ifdef SUBNIB_INV_EN
        test_inv();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
